mema_loader: RTL and testbench

MEMA_LOADER -- requirements
Module: mema_loader

---
 rtl/systolic_pkg.sv | 16 +
 rtl/cycle_counter.sv | 30 +++
 rtl/mema_loader.sv | 133 +++++++++++++
 tb/tb_mema_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic-array control blocks.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Shift cycles needed to push a DIM x DIM operand fully through the array.
  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Up-counter with enable, synchronous clear (dominant) and terminal-count flag.
module cycle_counter #(
  parameter int          W  = 4,
  parameter int unsigned TC = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == W'(TC));

endmodule

// File: rtl/mema_loader.sv
// Loads DIM rows into the A memory, then drives RUN_CYCLES shift enables.
// Optional abort input is enabled by defining MEMA_LOADER_ABORT_EN.
module mema_loader
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [DIM-1:0][BITS_AB-1:0]   in_row,
  input  logic                                 stall,
  output logic                                 WrEn,
  output logic        [$clog2(DIM)-1:0]        Arow,
  output logic signed [DIM-1:0][BITS_AB-1:0]   Ain,
  output logic                                 en,
  output logic                                 busy,
  output logic                                 done
`ifdef MEMA_LOADER_ABORT_EN
  ,
  input  logic                                 abort
`endif
);

  localparam int RUN_CYCLES = run_cycles(DIM);
  localparam int ROW_W      = $clog2(DIM);
  localparam int RUN_W      = $clog2(RUN_CYCLES);

  state_e state_q, state_d;

  logic             row_clr, row_inc, row_tc;
  logic             run_clr, run_inc, run_tc;
  logic [ROW_W-1:0] row_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             abort_req;

`ifdef MEMA_LOADER_ABORT_EN
  assign abort_req = abort && (state_q != ST_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  cycle_counter #(.W(ROW_W), .TC(DIM - 1)) u_row_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (row_clr),
    .en_i  (row_inc),
    .cnt_o (row_cnt),
    .tc_o  (row_tc)
  );

  cycle_counter #(.W(RUN_W), .TC(RUN_CYCLES - 1)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (run_clr),
    .en_i  (run_inc),
    .cnt_o (run_cnt),
    .tc_o  (run_tc)
  );

  // Counters are cleared on their final step so they idle at zero.
  always_comb begin
    state_d  = state_q;
    row_clr  = 1'b0;
    row_inc  = 1'b0;
    run_clr  = 1'b0;
    run_inc  = 1'b0;
    in_ready = 1'b0;
    WrEn     = 1'b0;
    en       = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          row_clr = 1'b1;
          run_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        WrEn     = in_valid;
        if (in_valid) begin
          if (row_tc) begin
            state_d = ST_RUN;
            row_clr = 1'b1;
            run_clr = 1'b1;
          end else begin
            row_inc = 1'b1;
          end
        end
      end
      ST_RUN: begin
        en = !stall;
        if (!stall) begin
          if (run_tc) begin
            state_d = ST_DONE;
            run_clr = 1'b1;
          end else begin
            run_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_req) begin
      state_d = ST_IDLE;
      row_clr = 1'b1;
      run_clr = 1'b1;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign busy = (state_q != ST_IDLE);
  assign Arow = row_cnt;
  assign Ain  = (state_q == ST_LOAD) ? in_row : '0;

  logic unused_run;
  assign unused_run = ^run_cnt;

endmodule

// File: tb/tb_mema_loader.sv
// Directed self-checking bench for mema_loader (DIM=8, BITS_AB=8).
module tb_mema_loader;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic                               start;
  logic                               in_valid;
  logic                               in_ready;
  logic signed [DIM-1:0][BITS_AB-1:0] in_row;
  logic                               stall;
  logic                               WrEn;
  logic        [$clog2(DIM)-1:0]      Arow;
  logic signed [DIM-1:0][BITS_AB-1:0] Ain;
  logic                               en;
  logic                               busy;
  logic                               done;
`ifdef MEMA_LOADER_ABORT_EN
  logic                               abort;
`endif

  int nvec = 0;
  int nerr = 0;

  mema_loader #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_row   (in_row),
    .stall    (stall),
    .WrEn     (WrEn),
    .Arow     (Arow),
    .Ain      (Ain),
    .en       (en),
    .busy     (busy),
    .done     (done)
`ifdef MEMA_LOADER_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DIM-1:0][BITS_AB-1:0] fill(input int v);
    logic signed [DIM-1:0][BITS_AB-1:0] r;
    for (int j = 0; j < DIM; j++) r[j] = BITS_AB'(v);
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_WrEn"},     64'(WrEn),     64'd0);
    chk({tag, "_Arow"},     64'(Arow),     64'd0);
    chk({tag, "_en"},       64'(en),       64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
  endtask

  // Enters with IDLE; leaves one edge later in LOAD at edge+1.
  task automatic start_seq();
    start    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("idle_busy",  64'(busy),     64'd0);
    chk("idle_ready", 64'(in_ready), 64'd0);
    chk("idle_wren",  64'(WrEn),     64'd0);
    chk("idle_arow",  64'(Arow),     64'd0);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load_rows(input int gap, input bit poke, input bit neg);
    for (int r = 0; r < DIM; r++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_row   = fill(99);
        #1;
        chk("gap_wren",  64'(WrEn),     64'd0);
        chk("gap_arow",  64'(Arow),     64'(r));
        chk("gap_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_row   = fill(neg ? -r : r);
      start    = poke && (r == 3);
      #1;
      chk("load_ready", 64'(in_ready), 64'd1);
      chk("load_wren",  64'(WrEn),     64'd1);
      chk("load_arow",  64'(Arow),     64'(r));
      chk("load_ain",   64'(Ain),      64'(fill(neg ? -r : r)));
      chk("load_en",    64'(en),       64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_phase(input int stall_at, input int stall_len, input bit poke, input int rst_at);
    int c, en_cnt, done_cnt, done_at;
    c = 0; en_cnt = 0; done_cnt = 0; done_at = -1;
    while (c < 80 && done_at < 0) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      start = poke && (c == 3);
      #1;
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_run");
        @(posedge clk); @(posedge clk); #2;
        chk("rst_hold_done", 64'(done), 64'd0);
        stall = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rel_busy", 64'(busy), 64'd0);
        chk("rst_rel_done", 64'(done), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        return;
      end
      chk("run_ctl", 64'({in_ready, WrEn}), 64'd0);
      if (done) begin
        done_cnt++;
        done_at = c;
        chk("done_en", 64'(en), 64'd0);
        start = poke;
      end else begin
        chk("run_en", 64'(en), 64'(!stall));
        if (en) en_cnt++;
      end
      @(posedge clk); #1;
      c++;
    end
    stall = 1'b0;
    start = 1'b0;
    #1;
    chk("en_total",  64'(en_cnt),   64'd22);
    chk("done_at",   64'(done_at),  64'(22 + stall_len));
    chk("done_cnt",  64'(done_cnt), 64'd1);
    chk("post_busy", 64'(busy),     64'd0);
    chk("post_done", 64'(done),     64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_row   = '0;
    stall    = 1'b0;
`ifdef MEMA_LOADER_ABORT_EN
    abort    = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back rows, plain run.
    start_seq();
    load_rows(0, 1'b0, 1'b0);
    run_phase(100, 0, 1'b0, -1);

    // Valid every third cycle, negative row data.
    start_seq();
    load_rows(2, 1'b0, 1'b1);
    run_phase(100, 0, 1'b0, -1);

    // Five-cycle stall in the middle of RUN.
    start_seq();
    load_rows(0, 1'b0, 1'b0);
    run_phase(6, 5, 1'b0, -1);

    // start poked in LOAD, RUN and DONE.
    start_seq();
    load_rows(0, 1'b1, 1'b0);
    run_phase(100, 0, 1'b1, -1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_restart_busy", 64'(busy), 64'd0);
    end

    // Reset in RUN, then a fresh sequence.
    start_seq();
    load_rows(0, 1'b0, 1'b0);
    run_phase(100, 0, 1'b0, 10);
    start_seq();
    load_rows(0, 1'b0, 1'b0);
    run_phase(100, 0, 1'b0, -1);

`ifdef MEMA_LOADER_ABORT_EN
    start_seq();
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      in_row   = fill(r);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("abort_pre_arow", 64'(Arow), 64'd4);
    abort = 1'b1;
    #1;
    chk("abort_cyc_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_arow", 64'(Arow), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done), 64'd0);
    end
    start_seq();
    load_rows(0, 1'b0, 1'b0);
    run_phase(100, 0, 1'b0, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
